// File: rtl/cont_servo_pwm_pkg.sv
// Shared constants, types and the speed-to-width map
// for the continuous-servo PWM stage.
package cont_servo_pkg;

  typedef logic [11:0] servo_width_t;

  localparam servo_width_t SERVO_MIN_US  = 12'd1000;
  localparam servo_width_t SERVO_CTR_US  = 12'd1500;
  localparam servo_width_t SERVO_MAX_US  = 12'd2000;
  localparam servo_width_t SERVO_STEP_US = 12'd4;

  // Signed 12-bit math: the raw range 988..2008 fits without overflow.
  function automatic servo_width_t speed_to_width(
    input logic signed [7:0] speed
  );
    logic signed [11:0] s;
    logic signed [11:0] w;
    s = {{4{speed[7]}}, speed};
    w = $signed(SERVO_CTR_US) + s * $signed(SERVO_STEP_US);
    if (w < $signed(SERVO_MIN_US)) begin
      return SERVO_MIN_US;
    end
    if (w > $signed(SERVO_MAX_US)) begin
      return SERVO_MAX_US;
    end
    return servo_width_t'(w);
  endfunction

endpackage

// File: rtl/cont_servo_pwm_if.sv
// Speed-command handshake between firmware bridge and
// the servo PWM stage.
interface cont_servo_pwm_if;

  logic       CMD_VALID;
  logic       CMD_READY;
  logic       CMD_CH;
  logic [7:0] CMD_SPEED;

  modport master (
    output CMD_VALID,
    output CMD_CH,
    output CMD_SPEED,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID,
    input  CMD_CH,
    input  CMD_SPEED,
    output CMD_READY
  );

endinterface

// File: rtl/cont_servo_pwm_chan.sv
// One servo channel: double-buffered width and the
// registered frame-position compare.
module servo_pwm_chan
  import cont_servo_pkg::*;
#(
  parameter int FR_W = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [FR_W-1:0] fr_cnt,
  input  logic         load,
  input  logic         force_ctr,
  input  logic         en,
  input  logic         wr_en,
  input  servo_width_t wr_w,
  output logic         pwm
);

  localparam int CW = (FR_W > 12) ? FR_W : 12;

  servo_width_t shadow_w;
  servo_width_t active_w;
  servo_width_t next_w;

  // A write or a watchdog force landing on the load edge
  // is forwarded so it lands in the frame that is starting.
  always_comb begin
    next_w = shadow_w;
    if (wr_en) begin
      next_w = wr_w;
    end else if (force_ctr) begin
      next_w = SERVO_CTR_US;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_w <= SERVO_CTR_US;
      active_w <= SERVO_CTR_US;
      pwm      <= 1'b0;
    end else begin
      shadow_w <= next_w;
      if (load) begin
        active_w <= next_w;
      end
      pwm <= en && (CW'(fr_cnt) < CW'(active_w));
    end
  end

endmodule

// File: rtl/cont_servo_pwm.sv
// Dual 50 Hz servo PWM generator with double-buffered
// speed commands and a frame watchdog.
module cont_servo_pwm
  import cont_servo_pkg::*;
#(
  parameter int TICKS_PER_US = 100,
  parameter int FRAME_US     = 20000,
  parameter int WDOG_FRAMES  = 25
) (
  input  logic        FAB_CLK,
  input  logic        FAB_RESET,
  input  logic        ENABLE,
  cont_servo_pwm_if.slave cmd,
  output logic [1:0]  SERVO_PWM,
  output logic        FRAME_TICK,
  output logic        WDOG_TRIP
);

  localparam int US_W =
    (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam int FR_W = $clog2(FRAME_US);
  localparam int WD_W = $clog2(WDOG_FRAMES + 1);

  logic [US_W-1:0] us_cnt;
  logic [FR_W-1:0] fr_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            us_tick;
  logic            frame_start;
  logic            ready;
  logic            accept;
  logic            wd_hit;
  logic            active_en;
  logic [1:0]      wr_en;
  servo_width_t    cmd_w;

  assign us_tick =
    (us_cnt == US_W'(TICKS_PER_US - 1));
  assign frame_start =
    us_tick && (fr_cnt == FR_W'(FRAME_US - 1));
  assign accept = cmd.CMD_VALID && ready;
  // Any accepted command, either channel, feeds the watchdog.
  assign wd_hit = frame_start && !accept &&
    (wd_cnt >= WD_W'(WDOG_FRAMES - 1));
  assign cmd_w = speed_to_width(cmd.CMD_SPEED);
  assign wr_en = {accept && cmd.CMD_CH,
                  accept && !cmd.CMD_CH};
  assign cmd.CMD_READY = ready;

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      us_cnt     <= '0;
      fr_cnt     <= '0;
      wd_cnt     <= '0;
      active_en  <= 1'b0;
      ready      <= 1'b0;
      FRAME_TICK <= 1'b0;
      WDOG_TRIP  <= 1'b0;
    end else begin
      us_cnt <= us_tick ? '0 : us_cnt + 1'b1;
      if (us_tick) begin
        fr_cnt <= (fr_cnt == FR_W'(FRAME_US - 1))
          ? '0 : fr_cnt + 1'b1;
      end
      FRAME_TICK <= frame_start;
      ready      <= !frame_start;
      if (frame_start) begin
        active_en <= ENABLE;
      end
      if (accept) begin
        wd_cnt    <= '0;
        WDOG_TRIP <= 1'b0;
      end else if (wd_hit) begin
        wd_cnt    <= WD_W'(WDOG_FRAMES);
        WDOG_TRIP <= 1'b1;
      end else if (frame_start) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_chan
    servo_pwm_chan #(
      .FR_W(FR_W)
    ) u_chan (
      .clk      (FAB_CLK),
      .rst      (FAB_RESET),
      .fr_cnt   (fr_cnt),
      .load     (frame_start),
      .force_ctr(wd_hit),
      .en       (active_en),
      .wr_en    (wr_en[i]),
      .wr_w     (cmd_w),
      .pwm      (SERVO_PWM[i])
    );
  end

endmodule

// File: tb/tb_cont_servo_pwm.sv
// Randomized bench for cont_servo_pwm against a
// frame-level behavioural model.
module tb_cont_servo_pwm;

  localparam int T = 1;
  localparam int F = 2500;
  localparam int W = 3;
  localparam int P = F * T;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] pwm;
  logic       tick;
  logic       trip;

  cont_servo_pwm_if bus ();

  cont_servo_pwm #(
    .TICKS_PER_US(T),
    .FRAME_US    (F),
    .WDOG_FRAMES (W)
  ) dut (
    .FAB_CLK   (clk),
    .FAB_RESET (rst),
    .ENABLE    (en),
    .cmd       (bus),
    .SERVO_PWM (pwm),
    .FRAME_TICK(tick),
    .WDOG_TRIP (trip)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // stimulus for the current cycle
  logic       s_rst = 1'b1;
  logic       s_en = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ch = 1'b0;
  logic [7:0] s_speed = 8'd0;

  // model state
  int c = 0;
  int last_tick = 0;
  int shadow [2];
  int active [2];
  int en_act = 0;
  int wd = 0;
  int m_trip = 0;
  bit acc_prev = 0;
  bit en_prev = 0;
  bit rst_prev = 1;
  int run [2];
  int last_w [2];
  int frame_hi [2];
  int prev_hi [2];

  function automatic int map(input int s);
    int w;
    w = 1500 + 4 * s;
    if (w < 1000) w = 1000;
    if (w > 2000) w = 2000;
    return w;
  endfunction

  task automatic check(input string name, input int act,
                       input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      if (n_err < 25)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                 name, act, exp, c);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      shadow[i] = 1500;
      active[i] = 1500;
      frame_hi[i] = 0;
    end
    en_act = 0;
    wd = 0;
    m_trip = 0;
    last_tick = 0;
    acc_prev = 0;
  endtask

  // Called once per cycle at the falling edge.
  task automatic cyc();
    bit exp_tick;
    bit exp_ready;
    bit acc;
    int fpos;
    if (rst_prev) begin
      c = 0;
      model_reset();
    end else begin
      c++;
      if (c % P == 0) begin
        en_act = en_prev;
        if (!acc_prev) begin
          wd++;
          if (wd >= W) begin
            wd = W;
            m_trip = 1;
            shadow[0] = 1500;
            shadow[1] = 1500;
          end
        end
        active[0] = shadow[0];
        active[1] = shadow[1];
        last_tick = c;
      end
    end
    exp_tick = (c > 0) && (c % P == 0);
    exp_ready = (c >= 1) && !exp_tick;
    fpos = c - last_tick;
    check("ready", int'(bus.CMD_READY), int'(exp_ready));
    check("tick", int'(tick), int'(exp_tick));
    check("trip", int'(trip), m_trip);
    for (int i = 0; i < 2; i++) begin
      check(i == 0 ? "pwm_left" : "pwm_right", int'(pwm[i]),
            int'(en_act != 0 && fpos >= 1 &&
                 fpos <= active[i] * T));
      if (exp_tick) begin
        prev_hi[i] = frame_hi[i];
        frame_hi[i] = 0;
      end
      if (pwm[i]) begin
        run[i]++;
        frame_hi[i]++;
      end else if (run[i] > 0) begin
        last_w[i] = run[i];
        run[i] = 0;
      end
    end
    rst = s_rst;
    en = s_en;
    bus.CMD_VALID = s_valid;
    bus.CMD_CH = s_ch;
    bus.CMD_SPEED = s_speed;
    acc = !s_rst && s_valid && exp_ready;
    if (acc) begin
      shadow[s_ch] = map(int'($signed(s_speed)));
      wd = 0;
      m_trip = 0;
    end
    acc_prev = acc;
    en_prev = s_en;
    rst_prev = s_rst;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc();
    end
  endtask

  // advance until the next cycle has frame position fp
  task automatic run_to(input int fp);
    int k;
    k = 0;
    while (((c + 1) % P) != fp && k <= 3 * P) begin
      step(1);
      k++;
    end
    if (k > 3 * P) begin
      n_err++;
      $display("FAIL run_to: no frame position %0d", fp);
    end
  endtask

  task automatic send(input logic ch, input logic [7:0] spd);
    int k;
    s_valid = 1'b1;
    s_ch = ch;
    s_speed = spd;
    k = 0;
    do begin
      step(1);
      k++;
    end while (!acc_prev && k < 10);
    s_valid = 1'b0;
    check("send_accepted", int'(acc_prev), 1);
  endtask

  initial begin
    run = '{0, 0};
    last_w = '{0, 0};
    prev_hi = '{0, 0};
    rst = 1'b1;
    en = 1'b0;
    bus.CMD_VALID = 1'b0;
    bus.CMD_CH = 1'b0;
    bus.CMD_SPEED = 8'd0;
    model_reset();

    check("map_min", map(-128), 1000);
    check("map_max", map(127), 2000);
    check("map_zero", map(0), 1500);
    check("map_50", map(50), 1700);

    step(3);
    s_rst = 1'b0;
    s_en = 1'b1;
    step(1);
    check("rst_ready", int'(bus.CMD_READY), 0);
    check("rst_pwm", int'(pwm), 0);
    step(1);
    check("ready_rise", int'(bus.CMD_READY), 1);

    // idle frames: neutral pulses, watchdog trips at third start
    run_to(0);
    step(1);
    check("first_tick", int'(tick), 1);
    run_to(0);
    step(1);
    run_to(0);
    check("trip_before", int'(trip), 0);
    step(1);
    check("trip_third", int'(trip), 1);
    check("idle_w_left", last_w[0], 1500);
    check("idle_w_right", last_w[1], 1500);

    // mid-frame command: current frame untouched
    run_to(1000);
    send(1'b0, 8'd50);
    step(1);
    check("trip_clear", int'(trip), 0);
    run_to(1600);
    check("cur_frame_left", last_w[0], 1500);
    run_to(0);
    step(1);
    run_to(1800);
    check("new_left", last_w[0], 1700);
    check("new_right", last_w[1], 1500);

    // clamp at both ends
    run_to(2100);
    send(1'b1, 8'h80);
    send(1'b0, 8'h7f);
    run_to(0);
    step(1);
    run_to(2200);
    check("clamp_right", last_w[1], 1000);
    check("clamp_left", last_w[0], 2000);

    // command held across a frame start
    run_to(0);
    s_valid = 1'b1;
    s_ch = 1'b1;
    s_speed = 8'hf6;
    step(1);
    check("held_ready_low", int'(bus.CMD_READY), 0);
    check("held_tick", int'(tick), 1);
    step(1);
    check("held_ready_high", int'(bus.CMD_READY), 1);
    s_valid = 1'b0;

    // ENABLE dropped mid-pulse
    run_to(700);
    s_en = 1'b0;
    run_to(0);
    step(1);
    s_en = 1'b1;
    check("drop_cur_left", prev_hi[0], 2000);
    check("drop_cur_right", prev_hi[1], 1000);
    run_to(0);
    step(1);
    check("drop_next_left", prev_hi[0], 0);
    check("drop_next_right", prev_hi[1], 0);
    run_to(1600);
    check("held_cmd_right", last_w[1], 1460);

    // randomized commands and enable flips
    for (int i = 0; i < 8 * P; i++) begin
      if (!s_valid && $urandom_range(0, 599) == 0) begin
        s_valid = 1'b1;
        s_ch = 1'($urandom_range(0, 1));
        s_speed = 8'($urandom);
      end
      if (((c + 1) % P) == P / 2 &&
          $urandom_range(0, 2) == 0)
        s_en = !s_en;
      step(1);
      if (acc_prev) s_valid = 1'b0;
    end
    if (s_valid) send(s_ch, s_speed);

    // reset in the middle of a pulse
    s_en = 1'b1;
    run_to(0);
    step(1);
    send(1'b0, 8'd20);
    run_to(800);
    s_rst = 1'b1;
    step(1);
    step(1);
    check("rst_mid_pwm", int'(pwm), 0);
    check("rst_mid_ready", int'(bus.CMD_READY), 0);
    step(2);
    s_rst = 1'b0;
    step(1);
    run_to(0);
    step(1);
    check("post_rst_tick", int'(tick), 1);
    check("post_rst_quiet_l", prev_hi[0], 0);
    check("post_rst_quiet_r", prev_hi[1], 0);
    run_to(1600);
    check("post_rst_left", last_w[0], 1500);
    check("post_rst_right", last_w[1], 1500);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cont_servo_pwm.md
# cont_servo_pwm

Fabric stage directly downstream of the MSS in the continuous-servo test design. It accepts per-wheel signed speed commands written by MSS firmware and generates two 50 Hz hobby-servo PWM outputs, one for the left wheel and one for the right. Commands are double-buffered, so a new command only takes effect at a frame boundary. A frame watchdog forces both servos to neutral if firmware stops issuing commands.

## Interface
Parameters:
- TICKS_PER_US, 100, FAB_CLK cycles per microsecond; must be ≥1.
- FRAME_US, 20000, PWM frame period in µs; must be >2000.
- WDOG_FRAMES, 25, count of consecutive frames with no accepted command before the watchdog trips.

Ports:
- FAB_CLK  in  1  fabric clock; the block's single clock domain.
- FAB_RESET  in  1  reset, synchronous and active-high.
- ENABLE  in  1  output enable, driven from M2F_GPO_0; sampled only at frame start.
- CMD_VALID  in  1  command strobe.
- CMD_READY  out  1  block can accept a command this cycle.
- CMD_CH  in  1  channel select: 0 = left, 1 = right.
- CMD_SPEED  in  8  signed two's-complement speed; 0 = stop.
- SERVO_PWM  out  2  registered PWM outputs; bit 0 = left, bit 1 = right.
- FRAME_TICK  out  1  one-cycle pulse on each frame-start cycle.
- WDOG_TRIP  out  1  sticky watchdog flag.

## Operation
- Prescaler `us_cnt` counts 0..TICKS_PER_US-1. `us_tick` is asserted on the wrap.
- Frame counter `fr_cnt` counts 0..FRAME_US-1 and advances on `us_tick`.
- Frame start is the cycle on which `us_tick` is high and `fr_cnt` = FRAME_US-1. On that cycle:
  - FRAME_TICK = 1.
  - Each `active_w[ch]` loads from `shadow_w[ch]`.
  - `active_en` loads ENABLE.
  - The watchdog count updates.
- Width mapping: `width_us` = 1500 + 4·CMD_SPEED.
  - Compute signed in 12 bits, then clamp to [1000, 2000].
  - Examples: -128 → 1000 (clamped from 988); 127 → 2000 (clamped from 2008); 0 → 1500.
- Handshake:
  - CMD_READY = 1 on every cycle except the frame-start cycle and reset cycles.
  - A command is accepted when CMD_VALID && CMD_READY; the clamped width is written to `shadow_w[CMD_CH]`.
  - CMD_VALID held high while READY is low is accepted on the next cycle where READY is high.
  - If several commands hit the same channel within one frame, the last one wins.
- PWM: SERVO_PWM[ch] is high while `active_en` && `fr_cnt` < `active_w[ch]`, otherwise low.
- ENABLE low at frame start: both outputs stay low for the whole frame. Counters and shadows keep running.
- Watchdog:
  - `wd_cnt` increments at each frame start and clears on any accepted command.
  - When `wd_cnt` reaches WDOG_FRAMES:
    - Both shadows are forced to 1500.
    - WDOG_TRIP is set.
    - `wd_cnt` saturates.
  - WDOG_TRIP clears on the next accepted command. A command on the same cycle as the trip takes priority: the trip is suppressed and the command is written.
- Reset values:
  - SERVO_PWM = 0, FRAME_TICK = 0, WDOG_TRIP = 0, CMD_READY = 0.
  - Counters = 0.
  - Shadows and actives = 1500.
  - `active_en` = 0.

## Timing
- All outputs are registered, with one cycle of latency from the internal compare.
- Pulse width = `width_us`·TICKS_PER_US cycles exactly. Frame = FRAME_US·TICKS_PER_US cycles.
- Rising edges of both channels are cycle-aligned, one cycle after FRAME_TICK.
- Command to output: a command takes effect at the first frame start strictly after the accept cycle.
- CMD_READY rises on the first cycle after FAB_RESET deasserts.
- Reset asserted mid-pulse: SERVO_PWM is low from the first edge that samples FAB_RESET = 1. After release, the first frame starts FRAME_US·TICKS_PER_US cycles later, with outputs low until then.
- Wrap-around: `fr_cnt` and `us_cnt` wrap without skipped or duplicated cycles.

## Structure
- Package `cont_servo_pkg` holds:
  - Constants: SERVO_MIN_US = 1000, SERVO_CTR_US = 1500, SERVO_MAX_US = 2000, SERVO_STEP_US = 4.
  - Typedef `servo_width_t` (12-bit unsigned).
  - Function `speed_to_width` (map plus clamp).
- Sub-module `servo_pwm_chan`, instantiated twice. It holds the shadow/active registers and the compare, and takes `fr_cnt`, the frame-start strobe and the write port.
- The prescaler, frame counter, watchdog and handshake logic live in the top module.

## Test plan
- The bench uses TICKS_PER_US = 1, FRAME_US = 2500, WDOG_FRAMES = 3.
- Reset, then ENABLE = 1, no commands → both PWM outputs give 1500-cycle pulses every 2500 cycles; WDOG_TRIP = 1 after the 3rd frame start.
- Write CMD_CH = 0, CMD_SPEED = 50 mid-frame → left pulse is 1700 from the next frame; the current frame is unchanged; right stays 1500; WDOG_TRIP clears.
- Write -128 to right and 127 to left → pulses of 1000 and 2000 (clamp check).
- Hold CMD_VALID across a frame-start cycle → READY is low for exactly that cycle, and the command is accepted on the following cycle.
- Drop ENABLE mid-pulse → the current pulse completes; the next frame has no pulses.
- Assert FAB_RESET mid-pulse → PWM is low next edge; shadows return to 1500; READY is low during reset.
